// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        REACT   = 3'd2,
        RESULT  = 3'd3,
        TIMEOUT = 3'd4,
        CHEAT   = 3'd5
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [3:0]  BCD_BLANK = 4'hF;

    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] res;
        int unsigned v;
        res = '0;
        v   = value;
        for (int i = 0; i < 8; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Cascaded decimal counter: each enabled step adds one with carry across DIGITS BCD digits.
module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS-1:0] next_bcd;
    logic                carry;

    always_comb begin
        next_bcd = bcd;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    next_bcd[4*i +: 4] = 4'd0;
                end else begin
                    next_bcd[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd <= '0;
        end else if (clr) begin
            bcd <= '0;
        end else if (en) begin
            bcd <= next_bcd;
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game: random wait, stimulus light, millisecond BCD timing and a best-time record.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DIGITS      = 4,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 12,
    parameter int TIMEOUT_MS  = 1000
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic                start,
    input  logic                react,
    input  logic                clr_best,
    output logic                stim,
    output logic [2:0]          state_o,
    output logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] best_bcd,
    output logic                best_valid,
    output logic                done
);

    localparam int TICK_CYCLES = CLK_HZ / 1000;
    localparam int DIV_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WAIT_W      = $clog2(MIN_WAIT_MS + 2**RAND_BITS);
    // Timeout fires on the tick that would carry the count from TIMEOUT_MS-1 up to TIMEOUT_MS.
    localparam logic [4*DIGITS-1:0] TIMEOUT_LAST = (4*DIGITS)'(to_bcd(TIMEOUT_MS - 1));

    if (TIMEOUT_MS < 1 || TIMEOUT_MS >= 10**DIGITS) begin : g_bad_timeout
        $error("TIMEOUT_MS must lie in 1 .. 10**DIGITS-1");
    end

    game_state_t         state;
    game_state_t         state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [WAIT_W-1:0]   wait_ms;
    logic [15:0]         lfsr;
    logic [4*DIGITS-1:0] count;
    logic                ms_tick;
    logic                entering;
    logic                cnt_clr;
    logic                cnt_en;

    assign ms_tick  = (div_cnt == DIV_W'(TICK_CYCLES - 1));
    assign entering = (state_next != state);
    assign cnt_clr  = entering && (state_next == WAIT);
    assign cnt_en   = (state == REACT) && ms_tick && !react;

    assign state_o  = state;
    assign bcd      = (state == CHEAT) ? {DIGITS{BCD_BLANK}} : count;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT;
            end
            WAIT: begin
                if (react) state_next = CHEAT;
                else if (ms_tick && wait_ms == '0) state_next = REACT;
            end
            REACT: begin
                if (react) state_next = RESULT;
                else if (ms_tick && count == TIMEOUT_LAST) state_next = TIMEOUT;
            end
            RESULT, TIMEOUT, CHEAT: begin
                if (start) state_next = WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            div_cnt <= '0;
            wait_ms <= '0;
            stim    <= 1'b0;
            done    <= 1'b0;
        end else begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
            if (entering && (state_next == WAIT || state_next == REACT)) begin
                div_cnt <= '0;
            end else if (ms_tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (cnt_clr) begin
                wait_ms <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[RAND_BITS-1:0]);
            end else if (state == WAIT && ms_tick && wait_ms != '0) begin
                wait_ms <= wait_ms - WAIT_W'(1);
            end
            stim <= (state_next == REACT);
            done <= entering && (state_next inside {RESULT, TIMEOUT, CHEAT});
        end
    end

    // The count is frozen on the react cycle, so it is already the result being recorded.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            best_bcd   <= '0;
            best_valid <= 1'b0;
        end else if (clr_best) begin
            best_bcd   <= '0;
            best_valid <= 1'b0;
        end else if (state == REACT && react && (!best_valid || count < best_bcd)) begin
            best_bcd   <= count;
            best_valid <= 1'b1;
        end
    end

    bcd_counter #(
        .DIGITS(DIGITS)
    ) u_counter (
        .clk(CLK100MHZ),
        .rst(rst),
        .clr(cnt_clr),
        .en(cnt_en),
        .bcd(count)
    );

endmodule
